// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Digit-serial unsigned adder. Operands are captured on a start request and
//   added DIGIT bits per clock, LSB digit first, over N = WIDTH/DIGIT cycles.
//   The full sum and carry-out are registered on the last RUN cycle and held
//   until the next completion or reset.
//
//   Optional feature: define SERIAL_ADDER_OVF_EN to add the registered ovf
//   output (two's-complement overflow of the same addition).
//
// Parameters
//   WIDTH  operand / sum width in bits (2..64)
//   DIGIT  bits added per cycle; must divide WIDTH exactly
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  begin an addition (honoured in IDLE and DONE, ignored in RUN)
//   a, b   unsigned operands
//   cin    carry-in
//   s      registered sum
//   c      registered carry-out
//   busy   high while in RUN
//   done   one-cycle completion pulse (state DONE)
//   ovf    signed overflow, registered with s (SERIAL_ADDER_OVF_EN only)
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             busy,
  output logic             done
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int IDX_W = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] s_reg;
  logic             c_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [IDX_W-1:0] base;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   digit_total;
  logic [WIDTH-1:0] sum_next;
  logic             last_digit;
  logic             capture;

  // Datapath for the current digit: slice both operands at position k, add
  // with the running carry, and merge the DIGIT result bits into the partial
  // sum so the last RUN edge can load s with the complete value.
  always_comb begin
    base        = IDX_W'(cnt_reg) * IDX_W'(DIGIT);
    a_dig       = a_reg[base +: DIGIT];
    b_dig       = b_reg[base +: DIGIT];
    digit_total = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_reg};
    sum_next    = acc_reg;
    sum_next[base +: DIGIT] = digit_total[DIGIT-1:0];
  end

  assign last_digit = (cnt_reg == CNT_W'(N - 1));
  assign capture    = start && ((state_reg == IDLE) || (state_reg == DONE));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_digit) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      s_reg     <= '0;
      c_reg     <= 1'b0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        a_reg     <= a;
        b_reg     <= b;
        carry_reg <= cin;
        acc_reg   <= '0;
        cnt_reg   <= '0;
      end else if (state_reg == RUN) begin
        acc_reg   <= sum_next;
        carry_reg <= digit_total[DIGIT];
        cnt_reg   <= cnt_reg + CNT_W'(1);
        if (last_digit) begin
          s_reg <= sum_next;
          c_reg <= digit_total[DIGIT];
        end
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // On the last digit the operand MSBs sit at the top of the current slice.
  // carry_into_msb = a_msb ^ b_msb ^ sum_msb, so overflow reduces to the
  // XOR of those three with the carry out of the MSB.
  logic ovf_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (!capture && (state_reg == RUN) && last_digit) begin
      ovf_reg <= a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^
                 digit_total[DIGIT-1] ^ digit_total[DIGIT];
    end
  end

  assign ovf = ovf_reg;
`endif

  assign s    = s_reg;
  assign c    = c_reg;
  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);

endmodule
